gpio_irq_debounce: RTL and testbench



---
 rtl/gpio_dbnc_pkg.sv | 26 ++
 rtl/gpio_dbnc_pin.sv | 116 +++++++++++
 rtl/gpio_irq_debounce.sv | 113 +++++++++++
 tb/tb_gpio_irq_debounce.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_dbnc_pkg.sv
// gpio_dbnc_pkg: shared types and helpers for the GPIO debounce / edge-IRQ block.
//   filter_state_e : per-pin filter FSM state (STABLE, COUNTING)
//   edge_evt_t     : accepted-edge event from one pin filter (rise, fall)
//   MinSyncStages  : shallowest synchroniser that is allowed
//   sat_add8       : 8-bit saturating add, used by the optional glitch counter
package gpio_dbnc_pkg;

  localparam int MinSyncStages = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } filter_state_e;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/gpio_dbnc_pin.sv
// gpio_dbnc_pin: synchroniser + debounce filter for a single GPIO pad.
// Optional feature macro: GPIO_DBNC_GLITCH_CNT_EN (adds glitch_o).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   pad_i               : raw asynchronous pad input
//   debounce_cycles_i   : required stable cycles; 0 behaves as 1
//   level_o             : debounced level (registered)
//   evt_o               : edge accepted on the coming clock edge (combinational,
//                         so the parent can register a pulse aligned with level_o)
//   glitch_o            : (macro only) a COUNTING->STABLE rejection happens on
//                         the coming clock edge (combinational)
module gpio_dbnc_pin
  import gpio_dbnc_pkg::*;
#(
  parameter int CntW       = 16,
  parameter int SyncStages = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pad_i,
  input  logic [CntW-1:0] debounce_cycles_i,
  output logic            level_o,
  output edge_evt_t       evt_o
`ifdef GPIO_DBNC_GLITCH_CNT_EN
  ,
  output logic            glitch_o
`endif
);

  // A synchroniser shallower than two flops is not safe; clamp silently.
  localparam int SyncDepth = (SyncStages < MinSyncStages) ? MinSyncStages : SyncStages;

  logic [SyncDepth-1:0] sync_q, sync_d;
  logic                 sample;
  filter_state_e        state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic [CntW-1:0]      thresh;
  logic [CntW:0]        cnt_plus1;
  logic                 accept;

  always_comb begin
    sync_d = {sync_q[SyncDepth-2:0], pad_i};
  end

  assign sample = sync_q[SyncDepth-1];

  // Threshold is taken live every cycle, so lowering it mid-window lets an
  // already-long count accept immediately and raising it stretches the window.
  assign thresh    = (debounce_cycles_i == '0) ? {{(CntW-1){1'b0}}, 1'b1} : debounce_cycles_i;
  assign cnt_plus1 = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  assign accept    = (cnt_plus1 >= {1'b0, thresh});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    evt_o   = '0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sample != level_q) begin
          if (accept) begin
            // T=1: the first differing cycle is already enough.
            level_d    = sample;
            evt_o.rise = sample;
            evt_o.fall = ~sample;
          end else begin
            state_d = COUNTING;
            cnt_d   = cnt_plus1[CntW-1:0];
          end
        end
      end
      COUNTING: begin
        if (sample == level_q) begin
          // Input went back before the window closed: glitch rejected.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (accept) begin
          level_d    = sample;
          evt_o.rise = sample;
          evt_o.fall = ~sample;
          state_d    = STABLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_plus1[CntW] ? {CntW{1'b1}} : cnt_plus1[CntW-1:0];
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

`ifdef GPIO_DBNC_GLITCH_CNT_EN
  assign glitch_o = (state_q == COUNTING) && (sample == level_q);
`endif

endmodule

// File: rtl/gpio_irq_debounce.sv
// gpio_irq_debounce: per-pin synchronise + debounce of GPIO pads, with edge
// interrupts (sticky pending bits and one-cycle pulses).
// Optional feature macro: GPIO_DBNC_GLITCH_CNT_EN adds glitch_cnt_o /
// glitch_cnt_clr_i (8-bit saturating count of rejected glitches, all pins).
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   gpio_pad_i         : raw asynchronous pad inputs
//   debounce_cycles_i  : stability window in cycles (0 treated as 1)
//   rise_en_i/fall_en_i: per-pin edge interrupt enables
//   irq_clear_i        : per-pin pending clear (write-1 pulse)
//   gpio_level_o       : debounced levels
//   irq_pending_o      : sticky pending bits
//   irq_pulse_o        : one-cycle pulse, aligned with the new gpio_level_o
module gpio_irq_debounce
  import gpio_dbnc_pkg::*;
#(
  parameter int NrPins     = 4,
  parameter int CntW       = 16,
  parameter int SyncStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NrPins-1:0] gpio_pad_i,
  input  logic [CntW-1:0]   debounce_cycles_i,
  input  logic [NrPins-1:0] rise_en_i,
  input  logic [NrPins-1:0] fall_en_i,
  input  logic [NrPins-1:0] irq_clear_i,
`ifdef GPIO_DBNC_GLITCH_CNT_EN
  input  logic              glitch_cnt_clr_i,
  output logic [7:0]        glitch_cnt_o,
`endif
  output logic [NrPins-1:0] gpio_level_o,
  output logic [NrPins-1:0] irq_pending_o,
  output logic [NrPins-1:0] irq_pulse_o
);

  edge_evt_t         evt [NrPins];
  logic [NrPins-1:0] pending_q, pending_d;
  logic [NrPins-1:0] pulse_q, pulse_d;
`ifdef GPIO_DBNC_GLITCH_CNT_EN
  logic [NrPins-1:0] glitch_vec;
`endif

  for (genvar gi = 0; gi < NrPins; gi++) begin : g_pin
    gpio_dbnc_pin #(
      .CntW       (CntW),
      .SyncStages (SyncStages)
    ) u_pin (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .pad_i             (gpio_pad_i[gi]),
      .debounce_cycles_i (debounce_cycles_i),
      .level_o           (gpio_level_o[gi]),
      .evt_o             (evt[gi])
`ifdef GPIO_DBNC_GLITCH_CNT_EN
      ,
      .glitch_o          (glitch_vec[gi])
`endif
    );
  end

  // Events are combinational from the pin filters, so registering them here
  // lands the pulse on the same edge as the level change.
  // A qualified event overrides a simultaneous clear (set wins).
  always_comb begin
    pending_d = pending_q & ~irq_clear_i;
    pulse_d   = '0;
    for (int i = 0; i < NrPins; i++) begin
      if ((evt[i].rise && rise_en_i[i]) || (evt[i].fall && fall_en_i[i])) begin
        pulse_d[i]   = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign irq_pending_o = pending_q;
  assign irq_pulse_o   = pulse_q;

`ifdef GPIO_DBNC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic [7:0] glitch_inc;

  // A clear coinciding with new glitches leaves just this cycle's increment.
  always_comb begin
    glitch_inc = '0;
    for (int i = 0; i < NrPins; i++) begin
      glitch_inc = sat_add8(glitch_inc, {7'd0, glitch_vec[i]});
    end
    glitch_cnt_d = glitch_cnt_clr_i ? glitch_inc : sat_add8(glitch_cnt_q, glitch_inc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_gpio_irq_debounce.sv
// tb_gpio_irq_debounce: scoreboard bench for gpio_irq_debounce.
// Expected values are queued with the cycle they are due and compared by a
// negedge monitor. Build with GPIO_DBNC_GLITCH_CNT_EN to also check the
// glitch counter.
module tb_gpio_irq_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pad = 4'h0;
  logic [15:0] dbc = 16'd4;
  logic [3:0]  rise_en = 4'h0;
  logic [3:0]  fall_en = 4'h0;
  logic [3:0]  clr = 4'h0;
  logic [3:0]  level, pend, pulse;
`ifdef GPIO_DBNC_GLITCH_CNT_EN
  logic        gclr = 1'b0;
  logic [7:0]  gcnt;
`endif

  gpio_irq_debounce #(
    .NrPins     (4),
    .CntW       (16),
    .SyncStages (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .gpio_pad_i        (pad),
    .debounce_cycles_i (dbc),
    .rise_en_i         (rise_en),
    .fall_en_i         (fall_en),
    .irq_clear_i       (clr),
`ifdef GPIO_DBNC_GLITCH_CNT_EN
    .glitch_cnt_clr_i  (gclr),
    .glitch_cnt_o      (gcnt),
`endif
    .gpio_level_o      (level),
    .irq_pending_o     (pend),
    .irq_pulse_o       (pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int F_LEVEL = 0;
  localparam int F_PEND  = 1;
  localparam int F_PULSE = 2;
  localparam int F_GCNT  = 3;

  typedef struct {
    int         cyc;
    int         field;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end else begin
      $display("ok   %s @cyc %0d: value=%0h", tag, cyc, got);
    end
  endtask

  // Insert keeping the queue ordered by due cycle.
  task automatic expect_at(input int at, input int field, input logic [7:0] v, input string tag);
    exp_t e;
    int   idx;
    e.cyc = at; e.field = field; e.exp = v; e.tag = tag;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  function automatic logic [7:0] observed(input int field);
    case (field)
      F_LEVEL: return {4'h0, level};
      F_PEND:  return {4'h0, pend};
      F_PULSE: return {4'h0, pulse};
`ifdef GPIO_DBNC_GLITCH_CNT_EN
      F_GCNT:  return gcnt;
`endif
      default: return 8'hXX;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) chk({mon_e.tag, "_late"}, cyc, mon_e.cyc);
      else                 chk(mon_e.tag, {24'd0, observed(mon_e.field)}, {24'd0, mon_e.exp});
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    // ---- reset with pads high ----
    pad = 4'hF; rise_en = 4'b0101; fall_en = 4'h0; dbc = 16'd4;
    for (int k = 1; k <= 3; k++) begin
      expect_at(k, F_LEVEL, 8'h0, "rst_level");
      expect_at(k, F_PEND,  8'h0, "rst_pend");
      expect_at(k, F_PULSE, 8'h0, "rst_pulse");
    end
    goto(3);
    rst = 1'b0;
    c = cyc;
    expect_at(c + 5, F_LEVEL, 8'h0, "post_rst_level_early");
    expect_at(c + 6, F_LEVEL, 8'hF, "post_rst_level");
    expect_at(c + 6, F_PULSE, 8'h5, "post_rst_pulse");
    expect_at(c + 6, F_PEND,  8'h5, "post_rst_pend");
    expect_at(c + 7, F_PULSE, 8'h0, "post_rst_pulse_end");
`ifdef GPIO_DBNC_GLITCH_CNT_EN
    expect_at(c + 6, F_GCNT,  8'h0, "post_rst_gcnt");
`endif
    goto(12);
    clr = 4'hF;
    expect_at(12, F_PEND, 8'h5, "pend_before_clr");
    expect_at(13, F_PEND, 8'h0, "pend_after_clr");
    goto(13);
    clr = 4'h0;

    // ---- bring pads low (falls disabled) ----
    goto(14);
    c = cyc;
    pad = 4'h0;
    expect_at(c + 5, F_LEVEL, 8'hF, "settle_level_early");
    expect_at(c + 6, F_LEVEL, 8'h0, "settle_level");
    expect_at(c + 6, F_PULSE, 8'h0, "settle_no_pulse");
    expect_at(c + 6, F_PEND,  8'h0, "settle_no_pend");
    goto(c + 8);

    // ---- glitch rejection on pin0 ----
    c = cyc;
    dbc = 16'd10;
    pad[0] = 1'b1;
    expect_at(c + 11, F_LEVEL, 8'h0, "glitch_level_a");
    expect_at(c + 14, F_LEVEL, 8'h0, "glitch_level_b");
    expect_at(c + 12, F_PULSE, 8'h0, "glitch_no_pulse");
    expect_at(c + 14, F_PEND,  8'h0, "glitch_no_pend");
`ifdef GPIO_DBNC_GLITCH_CNT_EN
    expect_at(c + 11, F_GCNT,  8'h0, "gcnt_before");
    expect_at(c + 12, F_GCNT,  8'h1, "gcnt_after");
`endif
    goto(c + 9);
    pad[0] = 1'b0;
    goto(c + 15);

    // ---- exact acceptance on pin1, pulse and pending ----
    c = cyc;
    rise_en = 4'hF; fall_en = 4'b0100;
    pad[1] = 1'b1;
    expect_at(c + 11, F_LEVEL, 8'h0, "acc_level_early");
    expect_at(c + 12, F_LEVEL, 8'h2, "acc_level");
    expect_at(c + 11, F_PULSE, 8'h0, "acc_pulse_early");
    expect_at(c + 12, F_PULSE, 8'h2, "acc_pulse");
    expect_at(c + 13, F_PULSE, 8'h0, "acc_pulse_end");
    expect_at(c + 12, F_PEND,  8'h2, "acc_pend");
    expect_at(c + 20, F_PEND,  8'h2, "acc_pend_sticky");
    expect_at(c + 21, F_PEND,  8'h0, "acc_pend_cleared");
    goto(c + 20);
    clr = 4'b0010;
    goto(c + 21);
    clr = 4'h0;
    goto(c + 22);

    // ---- set-vs-clear collision on pin2 fall ----
    c = cyc;
    rise_en = 4'b0010; dbc = 16'd4;
    pad[2] = 1'b1;
    expect_at(c + 6,  F_LEVEL, 8'h6, "col_rise_level");
    expect_at(c + 6,  F_PULSE, 8'h0, "col_rise_no_pulse");
    expect_at(c + 6,  F_PEND,  8'h0, "col_rise_no_pend");
    expect_at(c + 13, F_LEVEL, 8'h6, "col_level_early");
    expect_at(c + 14, F_LEVEL, 8'h2, "col_fall_level");
    expect_at(c + 14, F_PULSE, 8'h4, "col_fall_pulse");
    expect_at(c + 14, F_PEND,  8'h4, "col_set_wins");
    expect_at(c + 15, F_PEND,  8'h4, "col_pend_held");
    expect_at(c + 17, F_PEND,  8'h0, "col_pend_cleared");
    goto(c + 8);
    pad[2] = 1'b0;
    goto(c + 13);
    clr = 4'b0100;
    goto(c + 14);
    clr = 4'h0;
    goto(c + 16);
    clr = 4'b0100;
    goto(c + 17);
    clr = 4'h0;
    goto(c + 18);

    // ---- threshold lowered mid-window on pin3 ----
    c = cyc;
    dbc = 16'd100;
    pad[3] = 1'b1;
    expect_at(c + 30, F_LEVEL, 8'h2, "thr_level_before");
    expect_at(c + 31, F_LEVEL, 8'hA, "thr_level_accept");
    expect_at(c + 31, F_PULSE, 8'h0, "thr_no_pulse");
    expect_at(c + 31, F_PEND,  8'h0, "thr_no_pend");
    goto(c + 30);
    dbc = 16'd20;
    goto(c + 33);

    // ---- zero threshold, all edges disabled, 1-cycle pulse on pin0 ----
    c = cyc;
    rise_en = 4'h0; fall_en = 4'h0; dbc = 16'd0;
    pad[0] = 1'b1;
    expect_at(c + 2, F_LEVEL, 8'hA, "t0_level_before");
    expect_at(c + 3, F_LEVEL, 8'hB, "t0_level_high");
    expect_at(c + 4, F_LEVEL, 8'hA, "t0_level_low");
    expect_at(c + 3, F_PULSE, 8'h0, "t0_no_pulse_rise");
    expect_at(c + 4, F_PULSE, 8'h0, "t0_no_pulse_fall");
    expect_at(c + 5, F_PEND,  8'h0, "t0_no_pend");
`ifdef GPIO_DBNC_GLITCH_CNT_EN
    expect_at(c + 5, F_GCNT,  8'h1, "t0_gcnt_unchanged");
`endif
    goto(c + 1);
    pad[0] = 1'b0;
`ifdef GPIO_DBNC_GLITCH_CNT_EN
    goto(c + 6);
    gclr = 1'b1;
    expect_at(c + 7, F_GCNT, 8'h0, "gcnt_cleared");
    goto(c + 7);
    gclr = 1'b0;
`endif
    goto(c + 10);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
